// File: rtl/tile_window2d_stream.sv
// -----------------------------------------------------------------------------
// tile_window2d_stream
//
// Buffers one TILE_W x TILE_H tile of pixels loaded in raster order,
// PIX_PER_CLK pixels per beat. It then sweeps the tile and emits
// PIX_PER_CLK adjacent WIN_SIZE x WIN_SIZE windows per output beat.
// Loading and sweeping never overlap: a new tile is accepted only after the
// last window beat of the current tile has been taken.
//
// Build option:
//   TILE_WIN_ZERO_PAD_EN  When defined, windows are centred on every tile
//                         pixel and pixels outside the tile read as zero.
//                         When undefined, only windows lying entirely inside
//                         the tile are produced, and out_x/out_y give the
//                         window origin.
//
// Ports:
//   clk            clock; all state changes on the rising edge
//   rst_n          asynchronous active-low reset
//   load_valid     load beat valid
//   load_ready     high in LOAD; beat accepted on load_valid && load_ready
//   load_pixels    PIX_PER_CLK pixels; lane k at [k*DATA_W +: DATA_W]
//   out_valid      window beat valid
//   out_ready      consumer takes the beat on out_valid && out_ready
//   out_window     lane l, row i, col j at ((l*WIN_SIZE+i)*WIN_SIZE+j)*DATA_W
//   out_lane_mask  bit l set when lane l holds a legal window
//   out_x, out_y   lane-0 window origin (centre in padded mode)
//   out_last       final window beat of the tile
//   busy           high while sweeping
// -----------------------------------------------------------------------------
module tile_window2d_stream #(
  parameter int DATA_W      = 8,
  parameter int TILE_W      = 32,
  parameter int TILE_H      = 32,
  parameter int WIN_SIZE    = 3,
  parameter int PIX_PER_CLK = 4
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            load_valid,
  output logic                                            load_ready,
  input  logic [DATA_W*PIX_PER_CLK-1:0]                   load_pixels,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [DATA_W*PIX_PER_CLK*WIN_SIZE*WIN_SIZE-1:0] out_window,
  output logic [PIX_PER_CLK-1:0]                          out_lane_mask,
  output logic [$clog2(TILE_W)-1:0]                       out_x,
  output logic [$clog2(TILE_H)-1:0]                       out_y,
  output logic                                            out_last,
  output logic                                            busy
);

  localparam int XW    = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int YW    = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam int WBITS = DATA_W * PIX_PER_CLK * WIN_SIZE * WIN_SIZE;

`ifdef TILE_WIN_ZERO_PAD_EN
  localparam int R     = (WIN_SIZE - 1) / 2;
  localparam int X_LIM = TILE_W - 1;
  localparam int Y_LIM = TILE_H - 1;
`else
  localparam int X_LIM = TILE_W - WIN_SIZE;
  localparam int Y_LIM = TILE_H - WIN_SIZE;
`endif

  typedef enum logic {S_LOAD = 1'b0, S_SWEEP = 1'b1} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] tile_mem [TILE_H][TILE_W];

  logic [XW-1:0]       load_x;
  logic [YW-1:0]       load_y;
  logic [XW-1:0]       sx_p0;
  logic [YW-1:0]       sy_p0;
  logic                load_fire;
  logic                load_done;
  logic                out_fire;
  logic                issue;
  logic                x_wrap_p0;
  logic                last_p0;
  logic [WBITS-1:0]    win_p0;
  logic [PIX_PER_CLK-1:0] mask_p0;

  // Any coordinate outside the tile reads as zero, so no index ever leaves
  // the memory bounds whatever the parameters.
  function automatic logic [DATA_W-1:0] rd_pix(input int yy, input int xx);
    if (yy < 0 || yy >= TILE_H || xx < 0 || xx >= TILE_W) return '0;
    return tile_mem[YW'(yy)][XW'(xx)];
  endfunction

  assign load_fire = load_valid && load_ready;
  assign load_done = load_fire && (int'(load_y) == TILE_H - 1) &&
                     (int'(load_x) + PIX_PER_CLK >= TILE_W);
  assign out_fire  = out_valid && out_ready;
  // Fill the output register when it is empty or being drained, except when
  // the beat being drained is the tile's last one.
  assign issue     = (state == S_SWEEP) && (!out_valid || out_ready) &&
                     !(out_valid && out_last);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LOAD;
    else        state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:  if (load_done) state_nxt = S_SWEEP;
      S_SWEEP: if (out_fire && out_last) state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  // FSM outputs
  always_comb begin
    load_ready = (state == S_LOAD);
    busy       = (state == S_SWEEP);
  end

  // Tile storage: data only, never cleared by reset.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      for (int k = 0; k < PIX_PER_CLK; k++) begin
        tile_mem[load_y][XW'(int'(load_x) + k)] <= load_pixels[k*DATA_W +: DATA_W];
      end
    end
  end

  // Load pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_x <= '0;
      load_y <= '0;
    end else if (load_fire) begin
      if (int'(load_x) + PIX_PER_CLK >= TILE_W) begin
        load_x <= '0;
        load_y <= load_done ? '0 : load_y + YW'(1);
      end else begin
        load_x <= load_x + XW'(PIX_PER_CLK);
      end
    end
  end

  // ---- stage p0: window gather at sweep pointer (sx_p0, sy_p0) ----
  assign x_wrap_p0 = (int'(sx_p0) + PIX_PER_CLK > X_LIM);
  assign last_p0   = x_wrap_p0 && (int'(sy_p0) == Y_LIM);

  always_comb begin
    win_p0  = '0;
    mask_p0 = '0;
    for (int l = 0; l < PIX_PER_CLK; l++) begin
`ifdef TILE_WIN_ZERO_PAD_EN
      mask_p0[l] = 1'b1;
      for (int i = 0; i < WIN_SIZE; i++) begin
        for (int j = 0; j < WIN_SIZE; j++) begin
          win_p0[((l*WIN_SIZE+i)*WIN_SIZE+j)*DATA_W +: DATA_W] =
            rd_pix(int'(sy_p0) + i - R, int'(sx_p0) + l + j - R);
        end
      end
`else
      mask_p0[l] = (int'(sx_p0) + l <= X_LIM);
      if (mask_p0[l]) begin
        for (int i = 0; i < WIN_SIZE; i++) begin
          for (int j = 0; j < WIN_SIZE; j++) begin
            win_p0[((l*WIN_SIZE+i)*WIN_SIZE+j)*DATA_W +: DATA_W] =
              rd_pix(int'(sy_p0) + i, int'(sx_p0) + l + j);
          end
        end
      end
`endif
    end
  end

  // ---- stage p1: output register and sweep pointer advance ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_window    <= '0;
      out_lane_mask <= '0;
      out_x         <= '0;
      out_y         <= '0;
      out_last      <= 1'b0;
      sx_p0         <= '0;
      sy_p0         <= '0;
    end else if (issue) begin
      out_valid     <= 1'b1;
      out_window    <= win_p0;
      out_lane_mask <= mask_p0;
      out_x         <= sx_p0;
      out_y         <= sy_p0;
      out_last      <= last_p0;
      if (x_wrap_p0) begin
        sx_p0 <= '0;
        sy_p0 <= last_p0 ? '0 : sy_p0 + YW'(1);
      end else begin
        sx_p0 <= sx_p0 + XW'(PIX_PER_CLK);
      end
    end else if (out_fire && out_last) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tile_window2d_stream.sv
module tb_tile_window2d_stream;

  localparam int DW   = 8;
  localparam int TW   = 8;
  localparam int TH   = 8;
  localparam int WS   = 3;
  localparam int PPC  = 4;
  localparam int WB   = DW * PPC * WS * WS;
  localparam int NLB  = TW * TH / PPC;

  typedef struct packed {
    logic [WB-1:0]  win;
    logic [PPC-1:0] mask;
    logic [2:0]     x;
    logic [2:0]     y;
    logic           last;
  } beat_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               load_valid;
  logic               load_ready;
  logic [DW*PPC-1:0]  load_pixels;
  logic               out_valid;
  logic               out_ready;
  logic [WB-1:0]      out_window;
  logic [PPC-1:0]     out_lane_mask;
  logic [2:0]         out_x;
  logic [2:0]         out_y;
  logic               out_last;
  logic               busy;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    tile [TH][TW];
  beat_t exp_q [$];

  tile_window2d_stream #(
    .DATA_W(DW), .TILE_W(TW), .TILE_H(TH), .WIN_SIZE(WS), .PIX_PER_CLK(PPC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready), .load_pixels(load_pixels),
    .out_valid(out_valid), .out_ready(out_ready), .out_window(out_window),
    .out_lane_mask(out_lane_mask), .out_x(out_x), .out_y(out_y),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // mode 0: value = base + y*8 + x ; mode 1: random bytes
  task automatic fill_tile(input int mode, input int base);
    for (int y = 0; y < TH; y++)
      for (int x = 0; x < TW; x++)
        tile[y][x] = (mode == 0) ? ((base + y*TW + x) & 255) : int'($urandom_range(0, 255));
  endtask

  // Reference: enumerate window positions straight from the tile picture.
  function automatic void build_exp();
    beat_t b;
    int xlim, ylim, r, yy, xx, v;
    bit pad;
`ifdef TILE_WIN_ZERO_PAD_EN
    pad = 1'b1; xlim = TW - 1; ylim = TH - 1; r = (WS - 1) / 2;
`else
    pad = 1'b0; xlim = TW - WS; ylim = TH - WS; r = 0;
`endif
    exp_q.delete();
    for (int y = 0; y <= ylim; y++) begin
      for (int x = 0; x <= xlim; x += PPC) begin
        b = '0;
        b.x = 3'(x);
        b.y = 3'(y);
        b.last = (y == ylim) && (x + PPC > xlim);
        for (int l = 0; l < PPC; l++) begin
          b.mask[l] = pad || (x + l <= xlim);
          if (b.mask[l]) begin
            for (int i = 0; i < WS; i++) begin
              for (int j = 0; j < WS; j++) begin
                yy = y + i - r;
                xx = x + l + j - r;
                v = (yy >= 0 && yy < TH && xx >= 0 && xx < TW) ? tile[yy][xx] : 0;
                b.win[((l*WS+i)*WS+j)*DW +: DW] = 8'(v);
              end
            end
          end
        end
        exp_q.push_back(b);
      end
    end
  endfunction

  // gap: 0 continuous, 1 toggled 1-0-1-0, 2 random
  task automatic load_tile(input int gap);
    int beat = 0;
    int cyc = 0;
    bit rdy_prev = 1'b0;
    bit any_low = 1'b0;
    bit ph = 1'b0;
    int by, bx;
    load_valid = 1'b0;
    while (beat < NLB && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (load_valid && rdy_prev) beat++;
      if (beat < NLB && !load_ready) any_low = 1'b1;
      rdy_prev = load_ready;
      ph = ~ph;
      load_valid = (beat < NLB) &&
                   ((gap == 0) || (gap == 1 && ph) || (gap == 2 && $urandom_range(0, 1) == 1));
      by = beat / (TW / PPC);
      bx = (beat % (TW / PPC)) * PPC;
      for (int k = 0; k < PPC; k++)
        load_pixels[k*DW +: DW] = (beat < NLB) ? 8'(tile[by][bx+k]) : 8'h00;
    end
    load_valid = 1'b0;
    chk("load_beats", beat, NLB);
    chk("load_ready_during_load", any_low, 0);
  endtask

  // Called at the negedge right after the final load beat was accepted.
  task automatic sweep_tile(input int stall_at, input bit rnd_ready, input int abort_at,
                            output logic [WB-1:0] first_win);
    int idx = 0;
    int cyc = 0;
    int stall = 0;
    int n = exp_q.size();
    first_win = '0;
    chk("entry_out_valid", out_valid, 0);
    chk("entry_busy", busy, 1);
    while (idx < n && idx != abort_at && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (idx == stall_at && stall < 5) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      chk("out_valid", out_valid, 1);
      chk("load_ready_in_sweep", load_ready, 0);
      chk($sformatf("beat%0d", idx),
          {out_window, out_lane_mask, out_x, out_y, out_last}, exp_q[idx]);
      if (out_valid && out_ready) begin
        if (idx == 0) first_win = out_window;
        idx++;
      end
    end
    if (abort_at < 0) begin
      chk("sweep_beats", idx, n);
      @(negedge clk);
      chk("done_out_valid", out_valid, 0);
      chk("done_load_ready", load_ready, 1);
      chk("done_busy", busy, 0);
    end else begin
      chk("abort_reached", idx, abort_at);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WB-1:0] fw;
    logic [71:0]   lane0_a, lane0_b;
`ifdef TILE_WIN_ZERO_PAD_EN
    lane0_a = {8'd9, 8'd8, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    lane0_b = {8'd73, 8'd72, 8'd0, 8'd65, 8'd64, 8'd0, 8'd0, 8'd0, 8'd0};
`else
    lane0_a = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
    lane0_b = {8'd82, 8'd81, 8'd80, 8'd74, 8'd73, 8'd72, 8'd66, 8'd65, 8'd64};
`endif
    rst_n = 1'b0;
    load_valid = 1'b0;
    load_pixels = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_window", out_window, 0);
    chk("rst_mask", out_lane_mask, 0);
    chk("rst_xy", {out_x, out_y}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_load_ready", load_ready, 1);

    // Ramp tile, continuous load, always-ready consumer
    fill_tile(0, 0);
    build_exp();
    load_tile(0);
    sweep_tile(-1, 1'b0, -1, fw);
    chk("ramp_lane0", fw[71:0], lane0_a);

    // Toggled load_valid, 5-cycle stall on beat 3
    load_tile(1);
    sweep_tile(3, 1'b0, -1, fw);
    chk("stall_lane0", fw[71:0], lane0_a);

    // Reset pulsed while beat 6 is presented
    load_tile(0);
    out_ready = 1'b1;
    sweep_tile(-1, 1'b0, 6, fw);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_xy", {out_x, out_y, out_last}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_load_ready", load_ready, 1);
    load_tile(0);
    sweep_tile(-1, 1'b0, -1, fw);
    chk("after_abort_lane0", fw[71:0], lane0_a);

    // Back-to-back tiles, second offset by 64
    load_tile(0);
    sweep_tile(-1, 1'b0, -1, fw);
    fill_tile(0, 64);
    build_exp();
    load_tile(0);
    sweep_tile(-1, 1'b0, -1, fw);
    chk("second_tile_lane0", fw[71:0], lane0_b);

    // Random tiles, random gaps, random backpressure
    for (int t = 0; t < 4; t++) begin
      fill_tile(1, 0);
      build_exp();
      load_tile(2);
      sweep_tile(int'($urandom_range(0, 5)), 1'b1, -1, fw);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_window2d_stream.md
TILE_WINDOW2D_STREAM -- requirements
Module: tile_window2d_stream

Interface
REQ-001 Parameter DATA_W, default 8, bits per pixel.
REQ-002 Parameter TILE_W, default 32, tile width in pixels; SHALL be a multiple of PIX_PER_CLK.
REQ-003 Parameter TILE_H, default 32, tile height in pixels.
REQ-004 Parameter WIN_SIZE, default 3, square window edge; SHALL be odd, >=1, <=TILE_W and <=TILE_H.
REQ-005 Parameter PIX_PER_CLK, default 4, pixels per load beat and windows per output beat.
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 load_valid  input  1  load beat valid.
REQ-009 load_ready  output  1  block accepts load beat.
REQ-010 load_pixels  input  DATA_W*PIX_PER_CLK  lane k at bits [k*DATA_W +: DATA_W], raster order.
REQ-011 out_valid  output  1  window beat valid.
REQ-012 out_ready  input  1  consumer accepts window beat.
REQ-013 out_window  output  DATA_W*PIX_PER_CLK*WIN_SIZE*WIN_SIZE  lane l, row i, col j at offset ((l*WIN_SIZE+i)*WIN_SIZE+j)*DATA_W.
REQ-014 out_lane_mask  output  PIX_PER_CLK  bit l set when lane l holds a legal window.
REQ-015 out_x / out_y  output  clog2(TILE_W) / clog2(TILE_H)  window origin (or centre, padded mode) of lane 0.
REQ-016 out_last  output  1  final window beat of current tile.
REQ-017 busy  output  1  high in SWEEP.

Function
REQ-018 FSM states LOAD and SWEEP; LOAD -> SWEEP on acceptance of beat TILE_W*TILE_H/PIX_PER_CLK; SWEEP -> LOAD on accepted beat with out_last=1.
REQ-019 load_ready SHALL equal (state==LOAD); a beat is accepted when load_valid && load_ready; writes lanes to tile_mem[load_y][load_x+k]; load_x steps by PIX_PER_CLK, wraps to 0 with load_y+1 at TILE_W; gaps in load_valid SHALL not advance pointers.
REQ-020 Output register: first out_valid SHALL assert exactly 1 cycle after the SWEEP entry edge, then advance only on out_valid && out_ready.
REQ-021 While out_valid && !out_ready, out_window, out_lane_mask, out_x, out_y, out_last SHALL hold stable.
REQ-022 Valid mode: out_x steps 0, PIX_PER_CLK, ... while out_x <= TILE_W-WIN_SIZE; out_y 0..TILE_H-WIN_SIZE; window[l][i][j]=tile(out_y+i, out_x+l+j).
REQ-023 Valid mode: mask bit l = (out_x+l <= TILE_W-WIN_SIZE); masked lanes SHALL output zero pixels.
REQ-024 Beat with final x step of final row SHALL carry out_last=1; pointers then reset to (0,0).
REQ-025 Tile buffer not reloaded until SWEEP completes (no overlap of load and sweep).
REQ-026 All index arithmetic SHALL be wide enough that no out-of-range memory read occurs for any legal parameter set.

Reset
REQ-027 On rst_n low: state=LOAD, load_ready=1 after release, out_valid=0, out_last=0, busy=0, out_window/out_lane_mask/out_x/out_y=0, all pointers 0; tile_mem not cleared.
REQ-028 Reset asserted mid-LOAD or mid-SWEEP SHALL abort immediately; next tile restarts at pixel (0,0).

Configuration
REQ-029 Macro TILE_WIN_ZERO_PAD_EN: when defined, padded mode: out_x steps over 0..TILE_W-1, out_y 0..TILE_H-1, window[l][i][j]=tile(out_y+i-R, out_x+l+j-R), R=(WIN_SIZE-1)/2, out-of-tile pixels read as 0, out_lane_mask all ones.
REQ-030 When undefined, valid mode per REQ-022/023 only; no padding logic synthesised.

Verification (TILE_W=8, TILE_H=8, WIN_SIZE=3, PIX_PER_CLK=4, pixel value=y*8+x)
REQ-031 Valid mode, 16 load beats, out_ready=1 -> 12 out beats; beat 0 (0,0) lane0 window {0,1,2;8,9,10;16,17,18}, mask 1111; beat 1 (4,0) mask 0011; beat 11 (4,5) out_last=1.
REQ-032 Padded mode, same load -> 16 beats; beat 0 lane0 window {0,0,0;0,0,1;0,8,9}; beat 15 (4,7) lane3 window {54,55,0;62,63,0;0,0,0}, out_last=1.
REQ-033 out_ready low 5 cycles on beat 3 -> outputs bit-identical over all 5 cycles, beat 4 follows on the release cycle, no beat lost or duplicated.
REQ-034 load_valid toggled 1-0-1-0 -> load_ready stays 1, 16 accepted beats still required, content as REQ-031.
REQ-035 rst_n pulsed low during beat 6 of SWEEP -> out_valid=0 asynchronously, load_ready=1 after release, fresh 16-beat load and sweep reproduce REQ-031.
REQ-036 Two back-to-back tiles (second value+64) -> load_ready=0 throughout first sweep, second sweep beat 0 lane0 window {64,65,66;72,73,74;80,81,82}.
